// File: rtl/mpadder_wordserial_pkg.sv
// Shared definitions for the word-serial multi-precision adder:
// op encodings, controller states and the limb-count helper.
package mpadder_pkg;

   localparam logic [1:0] OP_ADD     = 2'b00;
   localparam logic [1:0] OP_SUB     = 2'b01;
   localparam logic [1:0] OP_ADD_SHR = 2'b10;
   localparam logic [1:0] OP_CLEAR   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_FIN  = 2'b10
   } state_t;

   // Number of WORD-bit limbs needed to cover a (width+1)-bit accumulator.
   function automatic int calc_nw(input int width, input int word);
      return (width + word) / word;
   endfunction

endpackage

// File: rtl/mpadder_wordserial_if.sv
// Operation request / status bundle between the Montgomery controller
// (master) and the word-serial accumulator (slave).
interface mpadder_wordserial_if #(
   parameter int WIDTH = 514
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] in_a;
   logic             busy;
   logic             done;
   logic [WIDTH:0]   result;
   logic             flag;
   logic             c_zero;
   logic             c_lsb;

   modport master (
      output start, op, in_a,
      input  busy, done, result, flag, c_zero, c_lsb
   );

   modport slave (
      input  start, op, in_a,
      output busy, done, result, flag, c_zero, c_lsb
   );
endinterface

// File: rtl/mpadder_wordserial_addsub.sv
// One limb of the ripple adder/subtractor: sum = a + (sub ? ~b : b) + cin.
module mp_word_addsub #(
   parameter int WORD = 128
) (
   input  logic [WORD-1:0] a,
   input  logic [WORD-1:0] b,
   input  logic            cin,
   input  logic            sub,
   output logic [WORD-1:0] sum,
   output logic            cout
);
   logic [WORD-1:0] b_eff;

   // Conditional inversion plus a single full-width add per limb.
   always_comb begin
      b_eff       = sub ? ~b : b;
      {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WORD{1'b0}}, cin};
   end
endmodule

// File: rtl/mpadder_wordserial.sv
// Word-serial accumulator C <= C op A over WIDTH+1 bits, one WORD-bit limb
// per cycle. The limb results go to a shadow register so C stays stable
// until the single-cycle commit in FIN.
module mpadder_wordserial
   import mpadder_pkg::*;
#(
   parameter int WIDTH = 514,
   parameter int WORD  = 128
) (
   input  logic                  clk,
   input  logic                  resetn,
   mpadder_wordserial_if.slave   bus
);
   localparam int NW   = calc_nw(WIDTH, WORD);
   localparam int PADW = NW * WORD;
   localparam int CW   = (NW > 1) ? $clog2(NW) : 1;

   state_t           state_reg, state_next;
   logic [1:0]       op_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH:0]   c_reg, c_next;
   logic             carry_reg;
   logic [CW-1:0]    cnt_reg;
   logic             flag_reg, flag_next;
   logic             done_reg;

   logic             is_sub;
   logic             last_limb;
   logic             carry_out;
   logic [PADW-1:0]  a_pad, c_pad, s_pad;
   logic [WORD-1:0]  a_limb [NW];
   logic [WORD-1:0]  c_limb [NW];
   logic [WORD-1:0]  limb_sum;
   logic             limb_cout;

   assign is_sub    = (op_reg == OP_SUB);
   assign last_limb = (cnt_reg == CW'(NW - 1));

   // Pad bits above WIDTH must contribute zero after the subtract inversion,
   // so A's pad is filled with is_sub (inverted to 0 inside the limb adder).
   // Bit WIDTH of A is a real zero-extension bit and inverts to 1 for SUB.
   // The carry into bit WIDTH+1 then lands in the padded shadow register.
   generate
      if (PADW > WIDTH + 1) begin : g_pad
         assign a_pad     = {{(PADW-WIDTH-1){is_sub}}, 1'b0, a_reg};
         assign c_pad     = {{(PADW-WIDTH-1){1'b0}}, c_reg};
         assign carry_out = |s_pad[PADW-1:WIDTH+1];
      end else begin : g_nopad
         assign a_pad     = {1'b0, a_reg};
         assign c_pad     = c_reg;
         assign carry_out = carry_reg;
      end
   endgenerate

   // Per-limb views of the operands and the shadow sum registers.
   genvar gi;
   generate
      for (gi = 0; gi < NW; gi++) begin : g_limb
         logic [WORD-1:0] s_limb_reg;

         assign a_limb[gi] = a_pad[gi*WORD +: WORD];
         assign c_limb[gi] = c_pad[gi*WORD +: WORD];
         assign s_pad[gi*WORD +: WORD] = s_limb_reg;

         // Capture this limb's sum on the RUN cycle that addresses it.
         always_ff @(posedge clk) begin
            if (!resetn) begin
               s_limb_reg <= '0;
            end else if (state_reg == ST_RUN && cnt_reg == CW'(gi)) begin
               s_limb_reg <= limb_sum;
            end
         end
      end
   endgenerate

   mp_word_addsub #(
      .WORD (WORD)
   ) u_addsub (
      .a    (c_limb[cnt_reg]),
      .b    (a_limb[cnt_reg]),
      .cin  (carry_reg),
      .sub  (is_sub),
      .sum  (limb_sum),
      .cout (limb_cout)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: CLEAR skips the limb loop entirely.
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         ST_IDLE: if (bus.start) state_next = (bus.op == OP_CLEAR) ? ST_FIN : ST_RUN;
         ST_RUN:  if (last_limb) state_next = ST_FIN;
         ST_FIN:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Commit value and flag for the FIN cycle.
   always_comb begin
      c_next    = c_reg;
      flag_next = flag_reg;
      unique case (op_reg)
         OP_ADD: begin
            c_next    = s_pad[WIDTH:0];
            flag_next = carry_out;
         end
         OP_SUB: begin
            c_next    = s_pad[WIDTH:0];
            flag_next = ~carry_out;
         end
         OP_ADD_SHR: begin
            c_next    = {carry_out, s_pad[WIDTH:1]};
            flag_next = carry_out;
         end
         default: begin
            c_next    = '0;
            flag_next = 1'b0;
         end
      endcase
   end

   // Operand latch, carry chain, limb counter, accumulator and done pulse.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         op_reg    <= OP_ADD;
         a_reg     <= '0;
         c_reg     <= '0;
         carry_reg <= 1'b0;
         cnt_reg   <= '0;
         flag_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         unique case (state_reg)
            ST_IDLE: begin
               if (bus.start) begin
                  op_reg    <= bus.op;
                  a_reg     <= bus.in_a;
                  carry_reg <= (bus.op == OP_SUB);
                  cnt_reg   <= '0;
               end
            end
            ST_RUN: begin
               carry_reg <= limb_cout;
               cnt_reg   <= last_limb ? '0 : cnt_reg + 1'b1;
            end
            ST_FIN: begin
               c_reg    <= c_next;
               flag_reg <= flag_next;
               done_reg <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy   = (state_reg != ST_IDLE);
   assign bus.done   = done_reg;
   assign bus.result = c_reg;
   assign bus.flag   = flag_reg;
   assign bus.c_zero = (c_reg == '0);
   assign bus.c_lsb  = c_reg[0];

endmodule
